pwm_duty_ctrl: RTL and testbench



---
 rtl/pwm_ctrl_pkg.sv | 40 ++++
 rtl/key_debounce.sv | 58 +++++
 rtl/pwm_duty_ctrl.sv | 151 +++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and the seven-segment decoder for the push-button PWM controller.
// Segment outputs are active-low with bit order {g,f,e,d,c,b,a}.
package pwm_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam int         NUM_CH    = 10;
    localparam int         NUM_KEYS  = 3;

    localparam int KEY_UP  = 0;
    localparam int KEY_DN  = 1;
    localparam int KEY_SEL = 2;

    typedef logic [7:0] duty_t;
    typedef logic [6:0] seg_t;

    function automatic seg_t hexToSeg(input logic [3:0] value);
        seg_t seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: two-flop synchronizer, stability counter, and a single-cycle
// pulse on each accepted press (debounced level falling 1 -> 0).
module key_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic keyN_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prevLevel_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only survives while every cycle disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            prevLevel_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= keyN_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            prevLevel_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= prevLevel_q & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Ten-channel LED PWM controller driven by debounced push buttons; duty edits land in
// shadow registers and are copied to the active set only at the period wrap.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int PWM_DIV      = 195,
    parameter int DUTY_STEP    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  PUSH,
    output logic [9:0]  LED,
    output logic [3:0]  SEL,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [NUM_KEYS-1:0] press;

    duty_t         shadow_q [NUM_CH];
    duty_t         shadow_d [NUM_CH];
    duty_t         active_q [NUM_CH];
    logic [3:0]    sel_q;
    logic [3:0]    sel_d;
    logic [PW-1:0] prescale_q;
    logic [PW-1:0] prescale_d;
    logic [7:0]    periodCnt_q;
    logic [7:0]    periodCnt_d;
    logic          tick;
    logic          wrap;
    logic [9:0]    led_q;
    seg_t          hex0_q;
    seg_t          hex1_q;
    seg_t          hex4_q;
    duty_t         curDuty;
    logic [8:0]    upSum;
    logic [8:0]    dnDiff;

    logic        unusedKey3;
    logic [31:0] unusedClkHz;
    assign unusedKey3  = PUSH[3];
    assign unusedClkHz = CLK_HZ;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uKeyUp (
        .clk_i   (CLK),
        .rst_i   (RST),
        .keyN_i  (PUSH[KEY_UP]),
        .press_o (press[KEY_UP])
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uKeyDn (
        .clk_i   (CLK),
        .rst_i   (RST),
        .keyN_i  (PUSH[KEY_DN]),
        .press_o (press[KEY_DN])
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uKeySel (
        .clk_i   (CLK),
        .rst_i   (RST),
        .keyN_i  (PUSH[KEY_SEL]),
        .press_o (press[KEY_SEL])
    );

    // Duty edits use the pre-advance channel, so select+up changes the old channel.
    always_comb begin
        shadow_d = shadow_q;
        sel_d    = sel_q;
        curDuty  = shadow_q[sel_q];
        upSum    = {1'b0, curDuty} + 9'(DUTY_STEP);
        dnDiff   = {1'b0, curDuty} - 9'(DUTY_STEP);
        if (press[KEY_UP] && !press[KEY_DN]) begin
            shadow_d[sel_q] = upSum[8] ? 8'hFF : upSum[7:0];
        end else if (press[KEY_DN] && !press[KEY_UP]) begin
            shadow_d[sel_q] = dnDiff[8] ? 8'h00 : dnDiff[7:0];
        end
        if (press[KEY_SEL]) begin
            sel_d = (sel_q == 4'(NUM_CH - 1)) ? 4'd0 : sel_q + 4'd1;
        end
    end

    always_comb begin
        tick        = (prescale_q == PW'(PWM_DIV - 1));
        prescale_d  = tick ? '0 : prescale_q + PW'(1);
        periodCnt_d = tick ? periodCnt_q + 8'd1 : periodCnt_q;
        wrap        = tick && (periodCnt_q == 8'hFF);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q       <= '0;
            prescale_q  <= '0;
            periodCnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            sel_q       <= sel_d;
            prescale_q  <= prescale_d;
            periodCnt_q <= periodCnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (wrap) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Registered compare keeps the LED pins glitch-free; they lag the counter by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                led_q[i] <= (periodCnt_q < active_q[i]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hex0_q <= SEG_ZERO;
            hex1_q <= SEG_ZERO;
            hex4_q <= SEG_ZERO;
        end else begin
            hex0_q <= hexToSeg(curDuty[3:0]);
            hex1_q <= hexToSeg(curDuty[7:4]);
            hex4_q <= hexToSeg(sel_q);
        end
    end

    assign LED  = led_q;
    assign SEL  = sel_q;
    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = SEG_BLANK;
    assign HEX3 = SEG_BLANK;
    assign HEX4 = hex4_q;
    assign HEX5 = SEG_BLANK;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: directed vector table, multi-cycle corner sequences and
// random key activity checked against an abstract duty/select model.
module tb_pwm_duty_ctrl;

    localparam int DEB     = 4;
    localparam int DIV     = 2;
    localparam int STEP    = 16;
    localparam int PERIOD  = 256 * DIV;
    localparam int SETTLE  = 2 * PERIOD + 80;

    logic       CLK;
    logic       RST;
    logic [3:0] PUSH;
    logic [9:0] LED;
    logic [3:0] SEL;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checkCount;
    int passCount;
    int modelDuty [10];
    int modelSel;
    int ledCount [10];

    typedef struct {
        logic [2:0] keys;
        int         hold;
        int         expSel;
        int         expDuty;
    } vec_t;

    vec_t vecs [9];

    pwm_duty_ctrl #(
        .CLK_HZ       (50_000_000),
        .DEBOUNCE_CYC (DEB),
        .PWM_DIV      (DIV),
        .DUTY_STEP    (STEP)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .PUSH (PUSH),
        .LED  (LED),
        .SEL  (SEL),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3),
        .HEX4 (HEX4),
        .HEX5 (HEX5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int expSeg(input int v);
        case (v)
            0:       return 32'h40;
            1:       return 32'h79;
            2:       return 32'h24;
            3:       return 32'h30;
            4:       return 32'h19;
            5:       return 32'h12;
            6:       return 32'h02;
            7:       return 32'h78;
            8:       return 32'h00;
            9:       return 32'h10;
            10:      return 32'h08;
            11:      return 32'h03;
            12:      return 32'h46;
            13:      return 32'h21;
            14:      return 32'h06;
            default: return 32'h0E;
        endcase
    endfunction

    // A clean press of at least DEB cycles counts once; shorter lows are bounces.
    function automatic void modelPress(input logic [2:0] keys, input int hold);
        if (hold < DEB) return;
        if (keys[0] && !keys[1]) begin
            modelDuty[modelSel] = (modelDuty[modelSel] + STEP > 255) ? 255 : modelDuty[modelSel] + STEP;
        end else if (keys[1] && !keys[0]) begin
            modelDuty[modelSel] = (modelDuty[modelSel] - STEP < 0) ? 0 : modelDuty[modelSel] - STEP;
        end
        if (keys[2]) modelSel = (modelSel + 1) % 10;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 10; i++) modelDuty[i] = 0;
        modelSel = 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkModelOutputs(input string tag);
        checkOutput({tag, "_sel"}, int'(SEL), modelSel);
        checkOutput({tag, "_hex0"}, int'(HEX0), expSeg(modelDuty[modelSel] % 16));
        checkOutput({tag, "_hex1"}, int'(HEX1), expSeg(modelDuty[modelSel] / 16));
        checkOutput({tag, "_hex4"}, int'(HEX4), expSeg(modelSel));
    endtask

    // Keys low across exactly 'hold' rising edges, then a long release so the next press re-arms.
    task automatic applyStimulus(input logic [2:0] keys, input int hold);
        @(negedge CLK);
        PUSH = {1'b1, ~keys};
        repeat (hold) @(negedge CLK);
        PUSH = 4'hF;
        repeat (12) @(negedge CLK);
    endtask

    task automatic measureLeds(input int n);
        for (int i = 0; i < 10; i++) ledCount[i] = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) ledCount[i] += int'(LED[i]);
            @(negedge CLK);
        end
    endtask

    task automatic checkAllLeds(input string tag);
        repeat (SETTLE) @(negedge CLK);
        measureLeds(PERIOD);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("%s_led%0d", tag, i), ledCount[i], modelDuty[i] * DIV);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found;
        logic prevLed;
        int oldDuty;
        logic [2:0] rk;
        int rh;

        checkCount = 0;
        passCount  = 0;
        modelReset();

        vecs[0] = '{3'b001, 4, 0, 16};
        vecs[1] = '{3'b001, 5, 0, 32};
        vecs[2] = '{3'b001, 4, 0, 48};
        vecs[3] = '{3'b001, 3, 0, 48};
        vecs[4] = '{3'b010, 6, 0, 32};
        vecs[5] = '{3'b011, 5, 0, 32};
        vecs[6] = '{3'b101, 4, 1, 0};
        vecs[7] = '{3'b010, 4, 1, 0};
        vecs[8] = '{3'b001, 4, 1, 16};

        // Reset with the up key held; it must not count as a press afterwards.
        RST  = 1'b1;
        PUSH = 4'b1110;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        PUSH = 4'hF;
        checkOutput("rst_led",  int'(LED),  0);
        checkOutput("rst_sel",  int'(SEL),  0);
        checkOutput("rst_hex0", int'(HEX0), 32'h40);
        checkOutput("rst_hex1", int'(HEX1), 32'h40);
        checkOutput("rst_hex2", int'(HEX2), 32'h7F);
        checkOutput("rst_hex3", int'(HEX3), 32'h7F);
        checkOutput("rst_hex4", int'(HEX4), 32'h40);
        checkOutput("rst_hex5", int'(HEX5), 32'h7F);
        measureLeds(2 * PERIOD);
        for (int i = 0; i < 10; i++) checkOutput($sformatf("rst_ledIdle%0d", i), ledCount[i], 0);
        checkModelOutputs("rstHeldKey");

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].keys, vecs[v].hold);
            modelPress(vecs[v].keys, vecs[v].hold);
            checkOutput($sformatf("vec%0d_sel", v),  int'(SEL),  vecs[v].expSel);
            checkOutput($sformatf("vec%0d_hex0", v), int'(HEX0), expSeg(vecs[v].expDuty % 16));
            checkOutput($sformatf("vec%0d_hex1", v), int'(HEX1), expSeg(vecs[v].expDuty / 16));
        end
        checkAllLeds("table");

        // Edit channel 1 just after its period starts: this period keeps the old duty.
        found   = 0;
        prevLed = LED[1];
        for (int k = 0; k < PERIOD + 100 && found == 0; k++) begin
            @(negedge CLK);
            if (LED[1] && !prevLed) found = 1;
            prevLed = LED[1];
        end
        checkOutput("midEdit_riseSeen", found, 1);
        oldDuty = modelDuty[1];
        fork
            measureLeds(PERIOD);
            applyStimulus(3'b001, 4);
        join
        modelPress(3'b001, 4);
        checkOutput("midEdit_oldPeriod", ledCount[1], oldDuty * DIV);
        measureLeds(PERIOD);
        checkOutput("midEdit_newPeriod", ledCount[1], modelDuty[1] * DIV);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'b100, 4);
            modelPress(3'b100, 4);
            checkOutput($sformatf("walk%0d_sel", k),  int'(SEL),  modelSel);
            checkOutput($sformatf("walk%0d_hex4", k), int'(HEX4), expSeg(modelSel));
        end

        applyStimulus(3'b100, 4);
        modelPress(3'b100, 4);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(3'b001, 4);
            modelPress(3'b001, 4);
            checkModelOutputs($sformatf("satUp%0d", k));
        end
        checkOutput("satTop_hex", int'({HEX1, HEX0}), 32'h070E);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(3'b010, 4);
            modelPress(3'b010, 4);
            checkModelOutputs($sformatf("satDn%0d", k));
        end
        checkOutput("satBot_hex", int'({HEX1, HEX0}), 32'h2040);

        for (int k = 0; k < 30; k++) begin
            rk = 3'($urandom_range(1, 7));
            rh = int'($urandom_range(2, 7));
            applyStimulus(rk, rh);
            modelPress(rk, rh);
            checkModelOutputs($sformatf("rand%0d", k));
        end
        checkAllLeds("random");

        // Pending shadow edit followed by reset mid-period: the edit must be lost.
        applyStimulus(3'b001, 4);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("midRst_led",  int'(LED),  0);
        checkOutput("midRst_sel",  int'(SEL),  0);
        checkOutput("midRst_hex0", int'(HEX0), 32'h40);
        checkOutput("midRst_hex1", int'(HEX1), 32'h40);
        checkOutput("midRst_hex4", int'(HEX4), 32'h40);
        RST = 1'b0;
        modelReset();
        checkAllLeds("postRst");
        checkModelOutputs("postRst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
